mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum WAIT-state cycles before an access is aborted (range 1..255).
REQ-002 The design SHALL use one clock; reset is asynchronous and active-high. Clock and reset ports: i_clk  in  1  clock; i_rst  in  1  reset.
REQ-003 Pipeline-register ports SHALL be:
- i_valid  in  1  instruction valid
- i_trap  in  1  upstream trap
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_is_word  in  1  word size
- i_is_h_or_b  in  1  halfword (1) or byte (0) when not word
- i_is_unsigned_ld  in  1  zero-extend load
- i_addr  in  32  byte address (EX result)
- i_store_data  in  32  rs2 value
- i_hold  in  1  downstream stage not accepting
REQ-004 Data-memory ports SHALL be:
- o_dmem_req  out  1  request
- o_dmem_we  out  1  write
- o_dmem_addr  out  32  word address
- o_dmem_wdata  out  32  write data
- o_dmem_wmask  out  4  byte enables
- i_dmem_ready  in  1  access complete this cycle
- i_dmem_rdata  in  32  read word, valid with ready
REQ-005 Result ports SHALL be:
- o_load_data  out  32  formatted load result
- o_stall  out  1  freeze the EX/MEM register and all earlier stages
- o_misaligned  out  1  alignment fault
- o_bus_err  out  1  timeout pulse

Function
REQ-006 access = i_valid & ~i_trap & (i_mem_read | i_mem_write) & ~o_misaligned; a store has priority if both read and write are set.
REQ-007 o_misaligned SHALL be combinational: 1 when i_valid & (read|write) & ((word & addr[1:0]!=0) | (half & addr[0]!=0)); no request or stall results.
REQ-008 FSM states SHALL be IDLE, WAIT and DONE, with a 2-bit state register and an 8-bit wait counter.
REQ-009 IDLE: o_dmem_req = access, issued in the same cycle. If ready, go to DONE when i_hold, else stay in IDLE. If not ready, go to WAIT with the counter at 1.
REQ-010 WAIT: req, addr, wdata, mask and we SHALL be held stable, and the counter SHALL increment each cycle. On ready, go to DONE if i_hold, else IDLE.
REQ-011 WAIT timeout: when the counter equals TIMEOUT_CYCLES and ready=0, drop req, pulse o_bus_err for 1 cycle, deassert stall, and return to IDLE. Ready in the same cycle wins over timeout.
REQ-012 DONE: req=0 and stall=0; o_load_data SHALL come from the captured register. Stay in DONE while i_hold; go to IDLE when i_hold=0. A new request is never reissued for the held instruction.
REQ-013 o_stall = (IDLE & access & ~ready) | (WAIT & ~ready & ~timeout); this is combinational, so a zero-wait access adds no stall.
REQ-014 o_dmem_addr = {i_addr[31:2], 2'b00}; o_dmem_we = i_mem_write.
REQ-015 Write mask and data:
- byte: mask 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}
- half: mask 4'b0011 << addr[1:0], wdata = {2{data[15:0]}}
- word: mask 4'b1111, wdata = data
- mask = 0 for loads
REQ-016 Load format: shifted = rdata >> 8*addr[1:0]. Byte/half results SHALL be sign-extended unless i_is_unsigned_ld, in which case they are zero-extended; word results are unmodified.
REQ-017 o_load_data SHALL be the formatted rdata in the completing cycle, the captured value in DONE, and otherwise 0. The capture register SHALL load on every completing load.
REQ-018 Stores complete on ready exactly like loads; o_load_data = 0 for stores.

Reset
REQ-019 On i_rst: state=IDLE, counter=0, capture register=0, o_bus_err=0. With inputs idle, every output is 0 during reset.
REQ-020 Reset asserted in WAIT SHALL drop o_dmem_req asynchronously, and the access is abandoned.

Verification
REQ-021 Byte load, addr=0x103, unsigned=0, rdata=0x80FF_1234, ready same cycle -> req=1, stall=0, o_load_data=0xFFFF_FF80, addr=0x100.
REQ-022 Halfword store, addr=0x202, data=0x0000_ABCD, ready after 3 cycles -> wmask=4'b1100, wdata=0xABCD_ABCD, stall=1 for exactly 3 cycles, req stable throughout.
REQ-023 Word load, addr=0x006 -> o_misaligned=1, req=0, stall=0.
REQ-024 TIMEOUT_CYCLES=4, ready never asserted -> stall=1 for 4 cycles, o_bus_err=1 for one cycle, then req=0 and state IDLE.
REQ-025 Word load completes with i_hold=1 for 2 more cycles, rdata changing -> o_load_data holds the captured value, no second req, IDLE after hold falls.
REQ-026 i_rst pulsed mid-WAIT -> req and stall fall immediately; the next access issues normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage. It drives a ready-handshaked data memory,
// formats load data, builds store byte enables and aborts an access if the memory never answers.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_trap,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_is_word,
  input  logic        i_is_h_or_b,
  input  logic        i_is_unsigned_ld,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic        i_hold,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wmask,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_load_data,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StDone = 2'd2} state_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] cap_q, cap_d;

  logic        rw, access, complete;
  logic        req, stall, bus_err;
  logic [31:0] shifted, fmt;
  logic [3:0]  mask;
  logic [31:0] wdata;

  assign rw           = i_mem_read | i_mem_write;
  assign o_misaligned = i_valid & rw &
                        ((i_is_word & (i_addr[1:0] != 2'b00)) |
                         (~i_is_word & i_is_h_or_b & i_addr[0]));
  assign access       = i_valid & ~i_trap & rw & ~o_misaligned;

  always_comb begin
    req     = 1'b0;
    stall   = 1'b0;
    bus_err = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        req   = access;
        cnt_d = 8'd0;
        if (access) begin
          if (i_dmem_ready) begin
            state_d = i_hold ? StDone : StIdle;
          end else begin
            stall   = 1'b1;
            state_d = StWait;
            cnt_d   = 8'd1;
          end
        end
      end
      StWait: begin
        // A ready arriving in the timeout cycle still completes the access.
        if (i_dmem_ready) begin
          req     = 1'b1;
          state_d = i_hold ? StDone : StIdle;
          cnt_d   = 8'd0;
        end else if (cnt_q == TimeoutVal) begin
          bus_err = 1'b1;
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          req   = 1'b1;
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        if (!i_hold) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign complete = req & i_dmem_ready;

  always_comb begin
    shifted = i_dmem_rdata >> {i_addr[1:0], 3'b000};
    if (i_mem_write) begin
      fmt = 32'd0;
    end else if (i_is_word) begin
      fmt = i_dmem_rdata;
    end else if (i_is_h_or_b) begin
      fmt = i_is_unsigned_ld ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end else begin
      fmt = i_is_unsigned_ld ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end
  end

  always_comb begin
    if (i_is_word) begin
      mask  = 4'b1111;
      wdata = i_store_data;
    end else if (i_is_h_or_b) begin
      mask  = 4'b0011 << i_addr[1:0];
      wdata = {2{i_store_data[15:0]}};
    end else begin
      mask  = 4'b0001 << i_addr[1:0];
      wdata = {4{i_store_data[7:0]}};
    end
  end

  assign cap_d = complete ? fmt : cap_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      cap_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  // Reset gates the handshake outputs so an in-flight access is dropped at once.
  assign o_dmem_req   = req & ~i_rst;
  assign o_stall      = stall & ~i_rst;
  assign o_bus_err    = bus_err & ~i_rst;
  assign o_dmem_we    = i_mem_write;
  assign o_dmem_addr  = {i_addr[31:2], 2'b00};
  assign o_dmem_wdata = wdata;
  assign o_dmem_wmask = i_mem_write ? mask : 4'b0000;
  assign o_load_data  = i_rst    ? 32'd0 :
                        complete ? fmt   :
                        (state_q == StDone) ? cap_q : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues the expected memory
// transactions and timeout events, and a negedge monitor pops and compares them.
module tb_mem_access_unit;
  localparam int unsigned To = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, trap, mem_read, mem_write, is_word, is_h_or_b, is_uns, hold;
  logic [31:0] addr, store_data;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic [3:0]  dmem_wmask;
  logic        stall, misaligned, bus_err;

  mem_access_unit #(.TIMEOUT_CYCLES(To)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_trap(trap), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_is_word(is_word), .i_is_h_or_b(is_h_or_b),
    .i_is_unsigned_ld(is_uns), .i_addr(addr), .i_store_data(store_data), .i_hold(hold),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_wmask(dmem_wmask), .i_dmem_ready(dmem_ready),
    .i_dmem_rdata(dmem_rdata), .o_load_data(load_data), .o_stall(stall),
    .o_misaligned(misaligned), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] ld;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every completion or timeout pulse must match the next queued entry.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req && dmem_ready) begin
        if (q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("kind_completion", 32'(e.is_err), 32'd0);
          check("dmem_addr", dmem_addr, e.addr);
          check("dmem_we", 32'(dmem_we), 32'(e.we));
          check("dmem_wmask", 32'(dmem_wmask), 32'(e.mask));
          if (e.we) check("dmem_wdata", dmem_wdata, e.wdata);
          check("load_data", load_data, e.ld);
        end
      end
      if (bus_err) begin
        if (q.size() == 0) begin
          check("unexpected_bus_err", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("kind_bus_err", 32'(e.is_err), 32'd1);
          check("bus_err_no_req", 32'(dmem_req), 32'd0);
          check("bus_err_no_stall", 32'(stall), 32'd0);
        end
      end
    end
  end

  task automatic push(input bit err, input logic [31:0] a, input logic we, input logic [3:0] m,
                      input logic [31:0] wd, input logic [31:0] ld);
    exp_t x;
    x.is_err = err; x.addr = a; x.we = we; x.mask = m; x.wdata = wd; x.ld = ld;
    q.push_back(x);
  endtask

  task automatic idle();
    valid = 0; trap = 0; mem_read = 0; mem_write = 0; is_word = 0; is_h_or_b = 0;
    is_uns = 0; addr = 0; store_data = 0; hold = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic op(input logic rd, input logic wr, input logic w, input logic hb,
                    input logic u, input logic [31:0] a, input logic [31:0] d);
    valid = 1; trap = 0; mem_read = rd; mem_write = wr; is_word = w; is_h_or_b = hb;
    is_uns = u; addr = a; store_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    idle();
    rst = 1;
    @(negedge clk);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    check("rst_load_data", load_data, 0);
    check("rst_wmask", 32'(dmem_wmask), 0);
    check("rst_misaligned", 32'(misaligned), 0);
    step();
    rst = 0;

    // Signed byte load, zero wait.
    op(1, 0, 0, 0, 0, 32'h103, 0);
    dmem_ready = 1; dmem_rdata = 32'h80FF_1234;
    push(0, 32'h100, 0, 4'b0000, 0, 32'hFFFF_FF80);
    @(negedge clk);
    check("byte_ld_req", 32'(dmem_req), 1);
    check("byte_ld_stall", 32'(stall), 0);
    step();
    // Unsigned halfword, signed half, signed byte, word load.
    op(1, 0, 0, 1, 1, 32'h102, 0);
    push(0, 32'h100, 0, 4'b0000, 0, 32'h0000_80FF);
    step();
    op(1, 0, 0, 1, 0, 32'h100, 0);
    push(0, 32'h100, 0, 4'b0000, 0, 32'h0000_1234);
    step();
    op(1, 0, 0, 0, 0, 32'h101, 0);
    push(0, 32'h100, 0, 4'b0000, 0, 32'h0000_0012);
    step();
    op(1, 0, 1, 0, 0, 32'h110, 0);
    push(0, 32'h110, 0, 4'b0000, 0, 32'h80FF_1234);
    step();
    // Byte store; read also set, store wins.
    op(1, 1, 0, 0, 0, 32'h301, 32'h1234_5678);
    push(0, 32'h300, 1, 4'b0010, 32'h7878_7878, 0);
    step();
    idle();
    step();

    // Halfword store, ready after three stalled cycles.
    op(0, 1, 0, 1, 0, 32'h202, 32'h0000_ABCD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hs_stall", 32'(stall), 1);
      check("hs_req", 32'(dmem_req), 1);
      check("hs_addr", dmem_addr, 32'h200);
      check("hs_mask", 32'(dmem_wmask), 32'b1100);
      step();
    end
    dmem_ready = 1;
    push(0, 32'h200, 1, 4'b1100, 32'hABCD_ABCD, 0);
    @(negedge clk);
    check("hs_done_stall", 32'(stall), 0);
    step();
    idle();

    // Misaligned word load.
    op(1, 0, 1, 0, 0, 32'h006, 0);
    @(negedge clk);
    check("mis_flag", 32'(misaligned), 1);
    check("mis_req", 32'(dmem_req), 0);
    check("mis_stall", 32'(stall), 0);
    step();
    idle();

    // Timeout: ready never arrives.
    op(1, 0, 1, 0, 0, 32'h400, 0);
    push(1, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall) cnt++;
      if (bus_err) break;
    end
    check("to_stall_cycles", 32'(cnt), To);
    step();
    idle();
    @(negedge clk);
    check("to_bus_err_once", 32'(bus_err), 0);
    check("to_req_low", 32'(dmem_req), 0);
    step();

    // Word load completing under hold.
    op(1, 0, 1, 0, 0, 32'h500, 0);
    hold = 1; dmem_ready = 1; dmem_rdata = 32'hDEAD_BEEF;
    push(0, 32'h500, 0, 4'b0000, 0, 32'hDEAD_BEEF);
    step();
    dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    check("hold_req1", 32'(dmem_req), 0);
    check("hold_ld1", load_data, 32'hDEAD_BEEF);
    step();
    dmem_rdata = 32'h2222_2222;
    @(negedge clk);
    check("hold_req2", 32'(dmem_req), 0);
    check("hold_ld2", load_data, 32'hDEAD_BEEF);
    step();
    hold = 0;
    @(negedge clk);
    check("hold_ld3", load_data, 32'hDEAD_BEEF);
    step();
    op(1, 0, 1, 0, 0, 32'h504, 0);
    dmem_rdata = 32'hCAFE_F00D;
    push(0, 32'h504, 0, 4'b0000, 0, 32'hCAFE_F00D);
    step();
    idle();
    @(negedge clk);
    check("post_hold_ld", load_data, 0);
    step();

    // Reset mid-WAIT.
    op(0, 1, 1, 0, 0, 32'h600, 32'h0000_0055);
    step();
    #2;
    check("rw_req_before", 32'(dmem_req), 1);
    check("rw_stall_before", 32'(stall), 1);
    rst = 1;
    #1;
    check("rw_req_async", 32'(dmem_req), 0);
    check("rw_stall_async", 32'(stall), 0);
    step();
    dmem_ready = 1;
    push(0, 32'h600, 1, 4'b1111, 32'h0000_0055, 0);
    rst = 0;
    @(negedge clk);
    check("rw_reissue_req", 32'(dmem_req), 1);
    step();
    idle();
    step();
    step();

    check("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
